div_five: RTL and testbench

DIV_FIVE -- requirements
Module: div_five

---
 rtl/div_five_if.sv | 25 ++
 rtl/div_five.sv | 159 +++++++++++++++
 tb/tb_div_five.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/div_five_if.sv
// Request/result bundle for the div_five fixed-point divider.
// The master side issues start/operands; the slave side returns the result and status flags.
interface div_five_if #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIV_WIDTH      = 17
);
    logic                             start;
    logic signed [DIVIDEND_WIDTH-1:0] dividend;
    logic        [DIV_WIDTH-1:0]      divisor;
    logic        [DIV_WIDTH-1:0]      quotient;
    logic                             done;
    logic                             busy;
    logic                             dz;
    logic                             ovf;

    modport master (
        output start, dividend, divisor,
        input  quotient, done, busy, dz, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, done, busy, dz, ovf
    );
endinterface

// File: rtl/div_five.sv
// Sequential restoring divider: Q16.16 two's-complement dividend over a sign-magnitude Q0.16
// divisor, producing a sign-magnitude Q0.16 quotient. Define DIV_FIVE_ROUND_EN for round-half-up.
module div_five #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIV_WIDTH      = 17
) (
    input  logic      clk,
    input  logic      rst,
    div_five_if.slave bus
);
    localparam int MAG_W = DIV_WIDTH - 1;
    localparam int CNT_W = $clog2(MAG_W) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MAG_W - 1);
    localparam logic [MAG_W-1:0] MAG_MAX   = '1;

    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;
    state_t state, state_nxt;

    logic signed [DIVIDEND_WIDTH-1:0] dividend_p0;
    logic        [DIV_WIDTH-1:0]      divisor_p0;
    logic                             load_ph;
    logic        [DIVIDEND_WIDTH-1:0] mag_a_p1;
    logic        [MAG_W-1:0]          mag_b_p1;
    logic                             sign_p1;
    logic        [MAG_W:0]            rem;
    logic        [MAG_W-1:0]          quo;
    logic        [CNT_W-1:0]          cnt;
    logic        [DIV_WIDTH-1:0]      quotient_r;
    logic                             dz_r;
    logic                             ovf_r;

    function automatic logic [DIVIDEND_WIDTH-1:0] abs_mag(input logic signed [DIVIDEND_WIDTH-1:0] v);
        return v[DIVIDEND_WIDTH-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [DIV_WIDTH-1:0] pack_q(input logic s, input logic [MAG_W-1:0] m);
        return {s & (|m), m};
    endfunction

`ifdef DIV_FIVE_ROUND_EN
    function automatic logic [MAG_W-1:0] round_sat(input logic [MAG_W-1:0] m,
                                                   input logic [MAG_W:0]   r,
                                                   input logic [MAG_W-1:0] b);
        if (({r, 1'b0} >= {2'b00, b}) && (m != MAG_MAX))
            return m + 1'b1;
        return m;
    endfunction
`endif

    logic [DIVIDEND_WIDTH-1:0] mag_b_ext;
    logic                      b_zero, a_zero, a_ge_b, early_exit;
    logic [MAG_W:0]            rem_sh, rem_nxt;
    logic                      rem_ge;
    logic [MAG_W-1:0]          quo_nxt, mag_fin;

    assign mag_b_ext  = {{(DIVIDEND_WIDTH-MAG_W){1'b0}}, mag_b_p1};
    assign b_zero     = (mag_b_p1 == '0);
    assign a_zero     = (mag_a_p1 == '0);
    assign a_ge_b     = (mag_a_p1 >= mag_b_ext);
    assign early_exit = b_zero | a_zero | a_ge_b;

    // One restoring step: the 17-bit remainder never exceeds 2*|b| after the shift.
    assign rem_sh  = rem << 1;
    assign rem_ge  = (rem_sh >= {1'b0, mag_b_p1});
    assign rem_nxt = rem_ge ? (rem_sh - {1'b0, mag_b_p1}) : rem_sh;
    assign quo_nxt = (quo << 1) | {{(MAG_W-1){1'b0}}, rem_ge};

`ifdef DIV_FIVE_ROUND_EN
    assign mag_fin = round_sat(quo_nxt, rem_nxt, mag_b_p1);
`else
    assign mag_fin = quo_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = LOAD;
            LOAD: if (load_ph)   state_nxt = early_exit ? DONE : DIV;
            DIV:  if (cnt == LAST_ITER) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dividend_p0 <= '0;
            divisor_p0  <= '0;
            load_ph     <= 1'b0;
            mag_a_p1    <= '0;
            mag_b_p1    <= '0;
            sign_p1     <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            cnt         <= '0;
            quotient_r  <= '0;
            dz_r        <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state)
                // Operands are captured only while idle; later start pulses are ignored.
                IDLE: begin
                    if (bus.start) begin
                        dividend_p0 <= bus.dividend;
                        divisor_p0  <= bus.divisor;
                        load_ph     <= 1'b0;
                    end
                end
                // First LOAD cycle forms magnitudes, second one classifies the operands.
                LOAD: begin
                    if (!load_ph) begin
                        mag_a_p1 <= abs_mag(dividend_p0);
                        mag_b_p1 <= divisor_p0[MAG_W-1:0];
                        sign_p1  <= dividend_p0[DIVIDEND_WIDTH-1] ^ divisor_p0[DIV_WIDTH-1];
                        load_ph  <= 1'b1;
                    end else if (b_zero) begin
                        quotient_r <= pack_q(sign_p1, MAG_MAX);
                        dz_r       <= 1'b1;
                        ovf_r      <= 1'b0;
                    end else if (a_zero) begin
                        quotient_r <= '0;
                        dz_r       <= 1'b0;
                        ovf_r      <= 1'b0;
                    end else if (a_ge_b) begin
                        quotient_r <= pack_q(sign_p1, MAG_MAX);
                        dz_r       <= 1'b0;
                        ovf_r      <= 1'b1;
                    end else begin
                        rem <= mag_a_p1[MAG_W:0];
                        quo <= '0;
                        cnt <= '0;
                    end
                end
                DIV: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        quotient_r <= pack_q(sign_p1, mag_fin);
                        dz_r       <= 1'b0;
                        ovf_r      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient = quotient_r;
    assign bus.dz       = dz_r;
    assign bus.ovf      = ovf_r;
    assign bus.done     = (state == DONE);
    assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_div_five.sv
// Randomised self-checking bench for div_five against an arithmetic reference model.
module tb_div_five;
    logic clk;
    logic rst;
    int   n_err;
    int   n_chk;
    logic [16:0] last_q;

    div_five_if bus ();

    div_five dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [31:0] dd, input logic [16:0] dv,
                                  output logic [16:0] q, output bit dz, output bit ovf,
                                  output int lat);
        longint unsigned a, b, mag, r;
        bit s;
        a   = dd[31] ? (64'h1_0000_0000 - {32'd0, dd}) : {32'd0, dd};
        b   = {48'd0, dv[15:0]};
        s   = dd[31] ^ dv[16];
        dz  = 0;
        ovf = 0;
        lat = 2;
        if (b == 0) begin
            dz  = 1;
            mag = 65535;
        end else if (a == 0) begin
            mag = 0;
        end else if (a >= b) begin
            ovf = 1;
            mag = 65535;
        end else begin
            lat = 18;
            mag = (a * 65536) / b;
            r   = (a * 65536) % b;
`ifdef DIV_FIVE_ROUND_EN
            if ((2 * r >= b) && (mag < 65535)) mag = mag + 1;
`else
            if (r > b) mag = 0;
`endif
        end
        q = {s && (mag != 0), mag[15:0]};
    endfunction

    task automatic run_op(input logic [31:0] dd, input logic [16:0] dv, input bit repulse);
        logic [16:0] eq;
        bit edz, eovf;
        int elat, n;
        model(dd, dv, eq, edz, eovf, elat);
        bus.dividend = dd;
        bus.divisor  = dv;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.done && n < 40) begin
            if (repulse && n == 5) begin
                bus.start    = 1'b1;
                bus.dividend = ~dd;
                bus.divisor  = dv ^ 17'h05555;
            end
            if (repulse && n == 6) bus.start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        last_q = bus.quotient;
        chk("latency", 32'(n), 32'(elat));
        chk("quotient", 32'(bus.quotient), 32'(eq));
        chk("dz", 32'(bus.dz), 32'(edz));
        chk("ovf", 32'(bus.ovf), 32'(eovf));
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk("quotient_hold", 32'(bus.quotient), 32'(eq));
    endtask

    task automatic back_to_back(input logic [31:0] da, input logic [16:0] va,
                                input logic [31:0] db, input logic [16:0] vb);
        logic [16:0] qa, qb;
        bit dza, ova, dzb, ovb;
        int la, lb, n;
        model(da, va, qa, dza, ova, la);
        model(db, vb, qb, dzb, ovb, lb);
        bus.dividend = da;
        bus.divisor  = va;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.dividend = db;
        bus.divisor  = vb;
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_lat_a", 32'(n), 32'(la));
        chk("b2b_q_a", 32'(bus.quotient), 32'(qa));
        @(posedge clk); #1;
        n = 1;
        while (!bus.done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        bus.start = 1'b0;
        chk("b2b_lat_b", 32'(n), 32'(lb + 2));
        chk("b2b_q_b", 32'(bus.quotient), 32'(qb));
        chk("b2b_flags_b", 32'({bus.dz, bus.ovf}), 32'({dzb, ovb}));
        @(posedge clk); #1;
        chk("b2b_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [31:0] m, dd;
        logic [16:0] dv;
        n_err        = 0;
        n_chk        = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_quotient", 32'(bus.quotient), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_flags", 32'({bus.dz, bus.ovf}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(32'h00008000, 17'h0C000, 1'b0);
`ifdef DIV_FIVE_ROUND_EN
        chk("vec_half_by_3q", 32'(last_q), 32'h0AAAB);
`else
        chk("vec_half_by_3q", 32'(last_q), 32'h0AAAA);
`endif
        run_op(32'hFFFF8000, 17'h0C000, 1'b0);
        run_op(32'h00004000, 17'h10000, 1'b0);
        chk("vec_dz", 32'(last_q), 32'h1FFFF);
        run_op(32'h00010000, 17'h08000, 1'b0);
        chk("vec_ovf", 32'(last_q), 32'h0FFFF);
        run_op(32'h00000000, 17'h18000, 1'b0);
        chk("vec_zero", 32'(last_q), 32'h00000);
        run_op(32'h80000000, 17'h0FFFF, 1'b0);
        run_op(32'h00000001, 17'h1FFFF, 1'b0);
        run_op(32'hFFFF0001, 17'h0FFFF, 1'b0);

        // Abort an operation mid-division with reset, then restart immediately.
        bus.dividend = 32'h00001234;
        bus.divisor  = 17'h04321;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(bus.done), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_quotient", 32'(bus.quotient), 32'd0);
        chk("abort_flags", 32'({bus.dz, bus.ovf}), 32'd0);
        rst = 1'b0;
        run_op(32'h00003000, 17'h1C000, 1'b0);

        run_op(32'h00002000, 17'h06000, 1'b1);
        back_to_back(32'h00008000, 17'h0C000, 32'hFFFFC000, 17'h07000);
        back_to_back(32'h00000100, 17'h00300, 32'h00020000, 17'h00001);

        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                dd = $urandom;
            end else begin
                m  = 32'($urandom_range(0, 65535));
                dd = ($urandom_range(0, 1) == 1) ? (32'd0 - m) : m;
            end
            dv = {1'($urandom_range(0, 1)), 16'($urandom)};
            if ($urandom_range(0, 15) == 0) dv[15:0] = 16'h0000;
            run_op(dd, dv, ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
